// File: rtl/nfc_command_pkg.sv
// Shared definitions for the NFC command arbiter.
//   - Field widths of the atomic command generator (ACG) command bus.
//   - Idle-pattern constants driven onto the ACG bus when no command is
//     being presented.
//   - Arbiter FSM state encoding.
package nfc_command_pkg;

    localparam int CmdW       = 8;
    localparam int OptW       = 3;
    localparam int NumDataW   = 16;
    localparam int CADataW    = 40;
    localparam int WriteDataW = 16;

    // The TargetWay idle value is all-ones and depends on NumberOfWays,
    // so it is built with '1 at the point of use.
    localparam logic [CmdW-1:0]    IdleCommand   = 8'h00;
    localparam logic [OptW-1:0]    IdleOption    = 3'b000;
    localparam logic [NumDataW-1:0] IdleNumOfData = 16'h0000;
    localparam logic               IdleCASelect  = 1'b1;
    localparam logic [CADataW-1:0] IdleCAData    = 40'h0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

endpackage

// File: rtl/nfc_rr_arbiter.sv
// Combinational round-robin pick.
//   iRequest : request vector, one bit per source
//   iPointer : index of the source with highest priority this round
//   oGrant   : one-hot grant of the first request at or after iPointer,
//              wrapping modulo NumberOfSources
//   oFound   : at least one request was present
module nfc_rr_arbiter #(
    parameter int NumberOfSources = 4,
    parameter int PtrW            = $clog2(NumberOfSources)
) (
    input  logic [NumberOfSources-1:0] iRequest,
    input  logic [PtrW-1:0]            iPointer,
    output logic [NumberOfSources-1:0] oGrant,
    output logic                       oFound
);

    always_comb begin
        int  idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        oGrant = '0;
        for (int i = 0; i < NumberOfSources; i++) begin
            idx = int'(iPointer) + i;
            if (idx >= NumberOfSources) begin
                idx = idx - NumberOfSources;
            end
            if (!found && iRequest[idx]) begin
                oGrant[idx] = 1'b1;
                found       = 1'b1;
            end
        end
        oFound = found;
    end

endmodule

// File: rtl/nfc_command_arbiter.sv
// Shares one ACG command port among NumberOfSources command sequencers.
//
// Ports:
//   iSystemClock, iReset       clock (rising edge), async active-low reset
//   iSrc_*                     packed per-source command, CA and write/read
//                              streams; source i occupies slice i
//   oSrc_CmdAccept             one-cycle pulse when the ACG takes the command
//   oSrc_Done                  one-cycle pulse when the command completes
//   oSrc_Grant                 one-hot grant while a command is held, else 0
//   oACG_*                     muxed command/CA/write/read signals
//   iACG_Ready, iACG_LastStep  ACG accept and completion strobes
//   oDebugState                current arbiter state (state_t encoding)
//
// Handshake: a source raises iSrc_Valid with stable command fields and holds
// them until oSrc_CmdAccept; the command transfers in the ISSUE cycle where
// iACG_Ready is 1. The grant stays locked to that source until
// iACG_LastStep, during which its write stream and read-ready are routed to
// the ACG; other sources see no ready and are simply not connected.
module nfc_command_arbiter
    import nfc_command_pkg::*;
#(
    parameter int NumberOfWays    = 4,
    parameter int NumberOfSources = 4
) (
    input  logic                                iSystemClock,
    input  logic                                iReset,
    input  logic [NumberOfSources-1:0]          iSrc_Valid,
    input  logic [CmdW*NumberOfSources-1:0]     iSrc_Command,
    input  logic [OptW*NumberOfSources-1:0]     iSrc_CommandOption,
    input  logic [NumberOfWays*NumberOfSources-1:0] iSrc_TargetWay,
    input  logic [NumDataW*NumberOfSources-1:0] iSrc_NumOfData,
    input  logic [NumberOfSources-1:0]          iSrc_CASelect,
    input  logic [CADataW*NumberOfSources-1:0]  iSrc_CAData,
    input  logic [WriteDataW*NumberOfSources-1:0] iSrc_WriteData,
    input  logic [NumberOfSources-1:0]          iSrc_WriteLast,
    input  logic [NumberOfSources-1:0]          iSrc_WriteValid,
    input  logic [NumberOfSources-1:0]          iSrc_ReadReady,
    output logic [NumberOfSources-1:0]          oSrc_CmdAccept,
    output logic [NumberOfSources-1:0]          oSrc_Done,
    output logic [NumberOfSources-1:0]          oSrc_Grant,
    output logic [CmdW-1:0]                     oACG_Command,
    output logic [OptW-1:0]                     oACG_CommandOption,
    output logic [NumberOfWays-1:0]             oACG_TargetWay,
    output logic [NumDataW-1:0]                 oACG_NumOfData,
    output logic                                oACG_CASelect,
    output logic [CADataW-1:0]                  oACG_CAData,
    output logic [WriteDataW-1:0]               oACG_WriteData,
    output logic                                oACG_WriteLast,
    output logic                                oACG_WriteValid,
    output logic                                oACG_ReadReady,
    input  logic                                iACG_Ready,
    input  logic                                iACG_LastStep,
    output logic [1:0]                          oDebugState
);

    localparam int PtrW = $clog2(NumberOfSources);

    state_t                     state_q, state_d;
    logic [NumberOfSources-1:0] grant_q, grant_d;
    logic [PtrW-1:0]            ptr_q, ptr_d;

    logic [NumberOfSources-1:0] arb_grant;
    logic                       arb_found;
    logic [PtrW-1:0]            grant_idx;
    logic [PtrW-1:0]            ptr_next;

    nfc_rr_arbiter #(
        .NumberOfSources (NumberOfSources),
        .PtrW            (PtrW)
    ) u_rr_arbiter (
        .iRequest (iSrc_Valid),
        .iPointer (ptr_q),
        .oGrant   (arb_grant),
        .oFound   (arb_found)
    );

    // Index of the held grant; the source after it leads the next round.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NumberOfSources; i++) begin
            if (grant_q[i]) begin
                grant_idx = PtrW'(i);
            end
        end
        if (grant_idx == PtrW'(NumberOfSources - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + PtrW'(1);
        end
    end

    // State register
    always_ff @(posedge iSystemClock or negedge iReset) begin
        if (!iReset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic. The grant is cleared on return to IDLE so a stale
    // one-hot can never steer the bus.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_d = arb_grant;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A source dropping its valid here is ignored: only
                // iACG_Ready releases the ISSUE state.
                if (iACG_Ready) begin
                    if (iACG_LastStep) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        ptr_d   = ptr_next;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (iACG_LastStep) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_next;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        oACG_Command       = IdleCommand;
        oACG_CommandOption = IdleOption;
        oACG_TargetWay     = '1;
        oACG_NumOfData     = IdleNumOfData;
        oACG_CASelect      = IdleCASelect;
        oACG_CAData        = IdleCAData;
        oACG_WriteData     = '0;
        oACG_WriteLast     = 1'b0;
        oACG_WriteValid    = 1'b0;
        oACG_ReadReady     = 1'b0;
        oSrc_Grant         = '0;
        oSrc_CmdAccept     = '0;
        oSrc_Done          = '0;

        for (int i = 0; i < NumberOfSources; i++) begin
            if (grant_q[i] && state_q == ST_ISSUE) begin
                oACG_Command       = iSrc_Command[CmdW*i +: CmdW];
                oACG_CommandOption = iSrc_CommandOption[OptW*i +: OptW];
                oACG_TargetWay     = iSrc_TargetWay[NumberOfWays*i +: NumberOfWays];
                oACG_NumOfData     = iSrc_NumOfData[NumDataW*i +: NumDataW];
                oACG_CASelect      = iSrc_CASelect[i];
                oACG_CAData        = iSrc_CAData[CADataW*i +: CADataW];
            end
            if (grant_q[i] && state_q != ST_IDLE) begin
                oACG_WriteData  = iSrc_WriteData[WriteDataW*i +: WriteDataW];
                oACG_WriteLast  = iSrc_WriteLast[i];
                oACG_WriteValid = iSrc_WriteValid[i];
                oACG_ReadReady  = iSrc_ReadReady[i];
            end
        end

        if (state_q != ST_IDLE) begin
            oSrc_Grant = grant_q;
        end
        if (state_q == ST_ISSUE && iACG_Ready) begin
            oSrc_CmdAccept = grant_q;
        end
        if ((state_q == ST_ISSUE && iACG_Ready && iACG_LastStep) ||
            (state_q == ST_BUSY && iACG_LastStep)) begin
            oSrc_Done = grant_q;
        end
    end

    assign oDebugState = state_q;

endmodule

// File: tb/tb_nfc_command_arbiter.sv
module tb_nfc_command_arbiter;
    import nfc_command_pkg::*;

    localparam int NW = 4;
    localparam int NS = 4;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [NS-1:0]      src_valid;
    logic [8*NS-1:0]    src_cmd;
    logic [3*NS-1:0]    src_opt;
    logic [NW*NS-1:0]   src_way;
    logic [16*NS-1:0]   src_num;
    logic [NS-1:0]      src_casel;
    logic [40*NS-1:0]   src_ca;
    logic [16*NS-1:0]   src_wd;
    logic [NS-1:0]      src_wl;
    logic [NS-1:0]      src_wv;
    logic [NS-1:0]      src_rr;
    logic [NS-1:0]      cmd_acc, done, grant;
    logic [7:0]         acg_cmd;
    logic [2:0]         acg_opt;
    logic [NW-1:0]      acg_way;
    logic [15:0]        acg_num;
    logic               acg_casel;
    logic [39:0]        acg_ca;
    logic [15:0]        acg_wd;
    logic               acg_wl, acg_wv, acg_rr;
    logic               acg_ready, acg_last;
    logic [1:0]         dbg_state;

    nfc_command_arbiter #(.NumberOfWays(NW), .NumberOfSources(NS)) dut (
        .iSystemClock       (clk),
        .iReset             (rst_n),
        .iSrc_Valid         (src_valid),
        .iSrc_Command       (src_cmd),
        .iSrc_CommandOption (src_opt),
        .iSrc_TargetWay     (src_way),
        .iSrc_NumOfData     (src_num),
        .iSrc_CASelect      (src_casel),
        .iSrc_CAData        (src_ca),
        .iSrc_WriteData     (src_wd),
        .iSrc_WriteLast     (src_wl),
        .iSrc_WriteValid    (src_wv),
        .iSrc_ReadReady     (src_rr),
        .oSrc_CmdAccept     (cmd_acc),
        .oSrc_Done          (done),
        .oSrc_Grant         (grant),
        .oACG_Command       (acg_cmd),
        .oACG_CommandOption (acg_opt),
        .oACG_TargetWay     (acg_way),
        .oACG_NumOfData     (acg_num),
        .oACG_CASelect      (acg_casel),
        .oACG_CAData        (acg_ca),
        .oACG_WriteData     (acg_wd),
        .oACG_WriteLast     (acg_wl),
        .oACG_WriteValid    (acg_wv),
        .oACG_ReadReady     (acg_rr),
        .iACG_Ready         (acg_ready),
        .iACG_LastStep      (acg_last),
        .oDebugState        (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] valid;
        logic       rdy;
        logic       last;
        logic [1:0] st;
        logic [3:0] grant;
        logic [3:0] acc;
        logic [3:0] done;
        logic [7:0] cmd;
        logic [3:0] way;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] v, input logic r, input logic l,
                                input logic [1:0] st, input logic [3:0] g,
                                input logic [3:0] a, input logic [3:0] d,
                                input logic [7:0] c, input logic [3:0] w);
        vec_t e;
        e.valid = v; e.rdy = r; e.last = l; e.st = st; e.grant = g;
        e.acc = a; e.done = d; e.cmd = c; e.way = w;
        return e;
    endfunction

    // ---------------- driver helpers ----------------
    task automatic drive_idle_inputs();
        src_valid = '0; src_wd = '0; src_wl = '0; src_wv = '0; src_rr = '0;
        acg_ready = 1'b0; acg_last = 1'b0;
    endtask

    task automatic check_idle_bus(input string tag);
        chk({tag, "_cmd"},   acg_cmd,   64'h00);
        chk({tag, "_opt"},   acg_opt,   64'h0);
        chk({tag, "_way"},   acg_way,   64'hF);
        chk({tag, "_num"},   acg_num,   64'h0);
        chk({tag, "_casel"}, acg_casel, 64'h1);
        chk({tag, "_ca"},    acg_ca,    64'h0);
        chk({tag, "_wv"},    acg_wv,    64'h0);
        chk({tag, "_wl"},    acg_wl,    64'h0);
        chk({tag, "_rr"},    acg_rr,    64'h0);
        chk({tag, "_grant"}, grant,     64'h0);
        chk({tag, "_acc"},   cmd_acc,   64'h0);
        chk({tag, "_done"},  done,      64'h0);
    endtask

    initial begin
        // Fixed per-source command fields.
        // cmd: src0 0x80, src1 0x85, src2 0x90, src3 0x60
        src_cmd   = {8'h60, 8'h90, 8'h85, 8'h80};
        src_opt   = {3'd4, 3'd3, 3'd2, 3'd1};
        src_way   = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
        src_num   = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
        src_casel = 4'b0000;
        src_ca    = {40'hA3_C0DE_0003, 40'h00_0000_0000, 40'hA1_C0DE_0001, 40'hA0_C0DE_0000};
        drive_idle_inputs();
        rst_n = 1'b0;

        // ---- reset state ----
        #3;
        check_idle_bus("reset");
        chk("reset_state", dbg_state, ST_IDLE);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- table: single command, then 0/1 alternation ----
        tbl.push_back(mk(4'b0000, 1, 1, ST_IDLE,  4'b0000, 4'b0000, 4'b0000, 8'h00, 4'hF));
        tbl.push_back(mk(4'b0100, 0, 0, ST_IDLE,  4'b0000, 4'b0000, 4'b0000, 8'h00, 4'hF));
        tbl.push_back(mk(4'b0000, 0, 0, ST_ISSUE, 4'b0100, 4'b0000, 4'b0000, 8'h90, 4'h4));
        tbl.push_back(mk(4'b0000, 0, 1, ST_ISSUE, 4'b0100, 4'b0000, 4'b0000, 8'h90, 4'h4));
        tbl.push_back(mk(4'b0100, 1, 0, ST_ISSUE, 4'b0100, 4'b0100, 4'b0000, 8'h90, 4'h4));
        for (int k = 0; k < 9; k++) begin
            tbl.push_back(mk(4'b0000, (k == 2), 0, ST_BUSY, 4'b0100, 4'b0000, 4'b0000, 8'h00, 4'hF));
        end
        tbl.push_back(mk(4'b0000, 0, 1, ST_BUSY,  4'b0100, 4'b0000, 4'b0100, 8'h00, 4'hF));
        tbl.push_back(mk(4'b0011, 0, 0, ST_IDLE,  4'b0000, 4'b0000, 4'b0000, 8'h00, 4'hF));
        tbl.push_back(mk(4'b0011, 1, 0, ST_ISSUE, 4'b0001, 4'b0001, 4'b0000, 8'h80, 4'h1));
        tbl.push_back(mk(4'b0011, 0, 1, ST_BUSY,  4'b0001, 4'b0000, 4'b0001, 8'h00, 4'hF));
        tbl.push_back(mk(4'b0011, 0, 0, ST_IDLE,  4'b0000, 4'b0000, 4'b0000, 8'h00, 4'hF));
        tbl.push_back(mk(4'b0011, 1, 0, ST_ISSUE, 4'b0010, 4'b0010, 4'b0000, 8'h85, 4'h2));
        tbl.push_back(mk(4'b0011, 0, 1, ST_BUSY,  4'b0010, 4'b0000, 4'b0010, 8'h00, 4'hF));
        tbl.push_back(mk(4'b0011, 0, 0, ST_IDLE,  4'b0000, 4'b0000, 4'b0000, 8'h00, 4'hF));
        tbl.push_back(mk(4'b0011, 0, 0, ST_ISSUE, 4'b0001, 4'b0000, 4'b0000, 8'h80, 4'h1));
        tbl.push_back(mk(4'b0011, 1, 1, ST_ISSUE, 4'b0001, 4'b0001, 4'b0001, 8'h80, 4'h1));
        tbl.push_back(mk(4'b0011, 0, 0, ST_IDLE,  4'b0000, 4'b0000, 4'b0000, 8'h00, 4'hF));
        tbl.push_back(mk(4'b0000, 1, 1, ST_ISSUE, 4'b0010, 4'b0010, 4'b0010, 8'h85, 4'h2));
        tbl.push_back(mk(4'b0000, 0, 0, ST_IDLE,  4'b0000, 4'b0000, 4'b0000, 8'h00, 4'hF));

        foreach (tbl[n]) begin
            @(negedge clk);
            src_valid = tbl[n].valid;
            acg_ready = tbl[n].rdy;
            acg_last  = tbl[n].last;
            #2;
            chk($sformatf("tbl%0d_state", n), dbg_state, tbl[n].st);
            chk($sformatf("tbl%0d_grant", n), grant,     tbl[n].grant);
            chk($sformatf("tbl%0d_acc", n),   cmd_acc,   tbl[n].acc);
            chk($sformatf("tbl%0d_done", n),  done,      tbl[n].done);
            chk($sformatf("tbl%0d_cmd", n),   acg_cmd,   tbl[n].cmd);
            chk($sformatf("tbl%0d_way", n),   acg_way,   tbl[n].way);
        end

        // ---- write stream routing for source 3 (pointer is 2 here) ----
        @(negedge clk);
        drive_idle_inputs();
        src_valid = 4'b1000;
        #2 chk("wr_idle_grant", grant, 64'h0);
        @(negedge clk);
        acg_ready = 1'b1;
        #2;
        chk("wr_issue_grant", grant,     64'h8);
        chk("wr_issue_acc",   cmd_acc,   64'h8);
        chk("wr_issue_cmd",   acg_cmd,   64'h60);
        chk("wr_issue_opt",   acg_opt,   64'h4);
        chk("wr_issue_way",   acg_way,   64'h8);
        chk("wr_issue_num",   acg_num,   64'h0103);
        chk("wr_issue_casel", acg_casel, 64'h0);
        chk("wr_issue_ca",    acg_ca,    64'hA3_C0DE_0003);
        @(negedge clk);
        acg_ready = 1'b0;
        src_valid = '0;
        #2;
        chk("wr_busy_state", dbg_state, ST_BUSY);
        chk("wr_busy_cmd",   acg_cmd,   64'h00);
        chk("wr_busy_casel", acg_casel, 64'h1);
        chk("wr_busy_acc",   cmd_acc,   64'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            src_wv = 4'b1001;
            src_wd[16*3 +: 16] = 16'(16'h1111 * (k + 1));
            src_wd[15:0]       = 16'hDEAD;
            src_wl = {(k == 3), 2'b00, (k != 3)};
            #2;
            chk($sformatf("wr_beat%0d_data", k), acg_wd, 16'(16'h1111 * (k + 1)));
            chk($sformatf("wr_beat%0d_valid", k), acg_wv, 64'h1);
            chk($sformatf("wr_beat%0d_last", k), acg_wl, (k == 3));
        end
        @(negedge clk);
        src_wv = '0; src_wl = '0; src_rr = 4'b1000;
        #2 chk("rd_ready_owner", acg_rr, 64'h1);
        @(negedge clk);
        src_rr = 4'b0001;
        #2 chk("rd_ready_other", acg_rr, 64'h0);
        @(negedge clk);
        src_rr = '0;
        acg_last = 1'b1;
        #2;
        chk("wr_done", done, 64'h8);
        chk("wr_done_grant", grant, 64'h8);
        @(negedge clk);
        acg_last = 1'b0;
        src_wv = 4'b0001; src_rr = 4'b0001; src_wl = 4'b0001;
        #2;
        chk("wr_after_state", dbg_state, ST_IDLE);
        chk("wr_after_wv",    acg_wv,    64'h0);
        chk("wr_after_wl",    acg_wl,    64'h0);
        chk("wr_after_rr",    acg_rr,    64'h0);
        chk("wr_after_done",  done,      64'h0);

        // ---- move the pointer to 2, then reset during BUSY of source 3 ----
        @(negedge clk);
        drive_idle_inputs();
        src_valid = 4'b0010;
        @(negedge clk);
        src_valid = '0;
        acg_ready = 1'b1; acg_last = 1'b1;
        #2;
        chk("rst_pre_acc",  cmd_acc, 64'h2);
        chk("rst_pre_done", done,    64'h2);
        @(negedge clk);
        acg_ready = 1'b0; acg_last = 1'b0;
        src_valid = 4'b1000;
        @(negedge clk);
        acg_ready = 1'b1;
        #2 chk("rst_pre_acc3", cmd_acc, 64'h8);
        @(negedge clk);
        acg_ready = 1'b0; src_valid = '0;
        src_wv = 4'b1000; src_wd[16*3 +: 16] = 16'h5555;
        #2;
        chk("rst_busy_state", dbg_state, ST_BUSY);
        chk("rst_busy_wv",    acg_wv,    64'h1);
        #2;
        rst_n = 1'b0;
        acg_last = 1'b1;
        #1;
        check_idle_bus("rst_async");
        chk("rst_async_state", dbg_state, ST_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle_inputs();
        src_valid = 4'b1001;
        #2 chk("rst_rel_state", dbg_state, ST_IDLE);
        @(negedge clk);
        #2;
        chk("rst_first_grant", grant,   64'h1);
        chk("rst_first_cmd",   acg_cmd, 64'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
